led_pattern_ctrl: RTL and testbench

Parametrised LED pattern controller: drives `LED_NUM` LEDs in one of six selectable patterns (off, flash, forward run, reverse run, breath, all-on). All patterns come from a single shared tick generator and a registered output stage. It replaces the fixed 4-LED selector at the board top level and adds three features: a restart on every mode change, selectable output polarity, and a pattern-cycle completion pulse.

---
 rtl/led_pattern_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: six-pattern LED driver with shared tick,
// mode-change restart, output polarity and cycle-done pulse.
module led_pattern_ctrl #(
  parameter int LED_NUM     = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int FLASH_TICKS = 5,
  parameter int RUN_TICKS   = 2,
  parameter int PWM_BITS    = 8,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [2:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               cycle_done
);

  typedef enum logic [2:0] {
    M_OFF    = 3'b000,
    M_FLASH  = 3'b001,
    M_RUNF   = 3'b010,
    M_BREATH = 3'b011,
    M_RUNR   = 3'b100,
    M_ALLON  = 3'b101,
    M_RSV6   = 3'b110,
    M_RSV7   = 3'b111
  } mode_e;

  localparam int TW   = $clog2(TICK_DIV) + 1;
  localparam int SMAX = (FLASH_TICKS > RUN_TICKS) ?
                        FLASH_TICKS : RUN_TICKS;
  localparam int SW   = $clog2(SMAX) + 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] FLASH_LAST = SW'(FLASH_TICKS - 1);
  localparam logic [SW-1:0] RUN_LAST   = SW'(RUN_TICKS - 1);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE =
    {{(PWM_BITS-1){1'b0}}, 1'b1};

  localparam logic [LED_NUM-1:0] PAT_LSB =
    {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] PAT_MSB =
    {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] POL = {LED_NUM{ACTIVE_LOW}};

  mode_e               r_act_mode, w_act_mode;
  logic [TW-1:0]       r_tick_cnt, w_tick_cnt;
  logic [SW-1:0]       r_step, w_step;
  logic [PWM_BITS-1:0] r_pwm, w_pwm;
  logic [PWM_BITS-1:0] r_duty, w_duty;
  logic                r_dir_up, w_dir_up;
  logic [LED_NUM-1:0]  r_pattern, w_pattern;
  logic                r_evt, w_evt;
  logic                w_tick;
  logic                w_chg;
  mode_e               w_req;

  function automatic logic [LED_NUM-1:0] init_pat(
    input mode_e m
  );
    logic [LED_NUM-1:0] p;
    p = '0;
    unique case (m)
      M_FLASH: p = '1;
      M_ALLON: p = '1;
      M_RUNF:  p = PAT_LSB;
      M_RUNR:  p = PAT_MSB;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Next-state: restart on mode change, else advance pattern.
  always_comb begin
    w_act_mode = r_act_mode;
    w_tick_cnt = r_tick_cnt;
    w_step     = r_step;
    w_pwm      = r_pwm;
    w_duty     = r_duty;
    w_dir_up   = r_dir_up;
    w_pattern  = r_pattern;
    w_evt      = 1'b0;
    w_req      = mode_e'(mode);
    w_tick     = (r_tick_cnt == TICK_LAST);
    w_chg      = (w_req != r_act_mode);
    if (w_chg) begin
      w_act_mode = w_req;
      w_tick_cnt = '0;
      w_step     = '0;
      w_pwm      = '0;
      w_duty     = '0;
      w_dir_up   = 1'b1;
      w_pattern  = init_pat(w_req);
    end else begin
      w_tick_cnt = w_tick ? '0 : r_tick_cnt + 1'b1;
      w_pwm      = r_pwm + 1'b1;
      unique case (r_act_mode)
        M_FLASH: begin
          if (w_tick) begin
            if (r_step == FLASH_LAST) begin
              w_step    = '0;
              w_pattern = ~r_pattern;
              w_evt     = ~r_pattern[0];
            end else begin
              w_step = r_step + 1'b1;
            end
          end
        end
        M_RUNF: begin
          if (w_tick) begin
            if (r_step == RUN_LAST) begin
              w_step    = '0;
              w_pattern = {r_pattern[LED_NUM-2:0],
                           r_pattern[LED_NUM-1]};
              w_evt     = r_pattern[LED_NUM-1];
            end else begin
              w_step = r_step + 1'b1;
            end
          end
        end
        M_RUNR: begin
          if (w_tick) begin
            if (r_step == RUN_LAST) begin
              w_step    = '0;
              w_pattern = {r_pattern[0],
                           r_pattern[LED_NUM-1:1]};
              w_evt     = r_pattern[0];
            end else begin
              w_step = r_step + 1'b1;
            end
          end
        end
        M_BREATH: begin
          w_pattern = {LED_NUM{r_pwm < r_duty}};
          if (r_pwm == PWM_MAX) begin
            if (r_dir_up) begin
              w_duty = r_duty + 1'b1;
              if (w_duty == PWM_MAX) w_dir_up = 1'b0;
            end else begin
              w_duty = r_duty - 1'b1;
              if (r_duty == PWM_ONE) begin
                w_dir_up = 1'b1;
                w_evt    = 1'b1;
              end
            end
          end
        end
        M_ALLON: w_pattern = '1;
        default: w_pattern = '0;
      endcase
    end
  end

  // State, pattern and registered output stage.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_mode <= M_OFF;
      r_tick_cnt <= '0;
      r_step     <= '0;
      r_pwm      <= '0;
      r_duty     <= '0;
      r_dir_up   <= 1'b1;
      r_pattern  <= '0;
      r_evt      <= 1'b0;
      led        <= POL;
      cycle_done <= 1'b0;
    end else begin
      r_act_mode <= w_act_mode;
      r_tick_cnt <= w_tick_cnt;
      r_step     <= w_step;
      r_pwm      <= w_pwm;
      r_duty     <= w_duty;
      r_dir_up   <= w_dir_up;
      r_pattern  <= w_pattern;
      r_evt      <= w_evt;
      led        <= r_pattern ^ POL;
      cycle_done <= r_evt;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed checks of reset, run,
// flash, breath, polarity and mode change on a tick edge.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode_a;
  logic [2:0] mode_b;
  logic [3:0] led_a;
  logic [3:0] led_b;
  logic       cd_a;
  logic       cd_b;

  int checks;
  int errors;

  led_pattern_ctrl #(
    .LED_NUM(4), .TICK_DIV(4), .FLASH_TICKS(2),
    .RUN_TICKS(1), .PWM_BITS(3), .ACTIVE_LOW(1'b0)
  ) u_a (
    .sys_clk(clk), .rst_n(rst_n), .mode(mode_a),
    .led(led_a), .cycle_done(cd_a)
  );

  led_pattern_ctrl #(
    .LED_NUM(4), .TICK_DIV(4), .FLASH_TICKS(2),
    .RUN_TICKS(1), .PWM_BITS(3), .ACTIVE_LOW(1'b1)
  ) u_b (
    .sys_clk(clk), .rst_n(rst_n), .mode(mode_b),
    .led(led_b), .cycle_done(cd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hi[15];
    int exp_hi[15] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0};
    int cd_cnt;
    int cd_at;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    mode_a = 3'b000;
    mode_b = 3'b000;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_led_a", 32'(led_a), 32'h0);
    chk("rst_cd_a", 32'(cd_a), 32'h0);
    chk("rst_led_b", 32'(led_b), 32'hF);

    edges(1);
    mode_a = 3'b010;
    rst_n  = 1'b1;
    edges(1);
    chk("runf_e0", 32'(led_a), 32'h0);
    edges(1);
    chk("runf_e1", 32'(led_a), 32'h1);
    edges(3);
    chk("runf_e4", 32'(led_a), 32'h1);
    edges(1);
    chk("runf_e5", 32'(led_a), 32'h2);
    edges(4);
    chk("runf_e9", 32'(led_a), 32'h4);
    edges(4);
    chk("runf_e13", 32'(led_a), 32'h8);
    chk("runf_cd13", 32'(cd_a), 32'h0);
    edges(3);
    chk("runf_e16", 32'(led_a), 32'h8);
    edges(1);
    chk("runf_wrap", 32'(led_a), 32'h1);
    chk("runf_cd", 32'(cd_a), 32'h1);
    edges(1);
    chk("runf_cd_end", 32'(cd_a), 32'h0);

    rst_n = 1'b0;
    #1;
    chk("midrst_led_a", 32'(led_a), 32'h0);
    chk("midrst_cd_a", 32'(cd_a), 32'h0);
    chk("midrst_led_b", 32'(led_b), 32'hF);
    rst_n = 1'b1;
    edges(1);
    chk("rel_f0", 32'(led_a), 32'h0);
    edges(1);
    chk("rel_f1", 32'(led_a), 32'h1);

    edges(12);
    chk("chg_f13", 32'(led_a), 32'h8);
    edges(2);
    mode_a = 3'b001;
    edges(1);
    chk("chg_f16", 32'(led_a), 32'h8);
    chk("chg_cd16", 32'(cd_a), 32'h0);
    edges(1);
    chk("chg_f17", 32'(led_a), 32'hF);
    chk("chg_cd17", 32'(cd_a), 32'h0);

    edges(7);
    chk("fl_on_end", 32'(led_a), 32'hF);
    edges(1);
    chk("fl_off", 32'(led_a), 32'h0);
    chk("fl_off_cd", 32'(cd_a), 32'h0);
    edges(7);
    chk("fl_off_end", 32'(led_a), 32'h0);
    edges(1);
    chk("fl_on2", 32'(led_a), 32'hF);
    chk("fl_on2_cd", 32'(cd_a), 32'h1);
    edges(1);
    chk("fl_cd_end", 32'(cd_a), 32'h0);

    mode_a = 3'b011;
    for (int p = 0; p < 15; p++) hi[p] = 0;
    cd_cnt = 0;
    cd_at  = 0;
    edges(1);
    for (int k = 1; k <= 125; k++) begin
      edges(1);
      if (k >= 2 && k <= 121) hi[(k-2)/8] += int'(led_a[0]);
      if (cd_a === 1'b1) begin
        cd_cnt++;
        cd_at = k;
      end
    end
    for (int p = 0; p < 15; p++)
      chk($sformatf("br_duty%0d", p), 32'(hi[p]), 32'(exp_hi[p]));
    chk("br_cd_cnt", 32'(cd_cnt), 32'd1);
    chk("br_cd_at", 32'(cd_at), 32'd113);

    mode_a = 3'b101;
    mode_b = 3'b100;
    edges(1);
    chk("rr_j0", 32'(led_b), 32'hF);
    edges(1);
    chk("allon", 32'(led_a), 32'hF);
    chk("rr_j1", 32'(led_b), 32'h7);
    mode_a = 3'b110;
    edges(2);
    chk("off110", 32'(led_a), 32'h0);
    mode_a = 3'b111;
    edges(2);
    chk("off111", 32'(led_a), 32'h0);
    chk("rr_j5", 32'(led_b), 32'hB);
    edges(4);
    chk("rr_j9", 32'(led_b), 32'hD);
    edges(4);
    chk("rr_j13", 32'(led_b), 32'hE);
    chk("rr_cd13", 32'(cd_b), 32'h0);
    edges(4);
    chk("rr_j17", 32'(led_b), 32'h7);
    chk("rr_cd17", 32'(cd_b), 32'h1);
    chk("off_cd", 32'(cd_a), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
